eth_tx_fsm: RTL and testbench

- Egress-side partner of the ingress packet FSM.
- Drains 34-bit {eop,sop,data} words from the output buffer the ingress FSM fills.
- Re-frames them into a 32-bit valid/ready stream with sop/eop, enforces an inter-packet gap (IPG), and counts packets and framing errors.
- Sits between the per-port output FIFO and the port transmit logic.

---
 rtl/eth_tx_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_eth_tx_fsm.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_fsm.sv
`default_nettype none
// eth_tx_fsm: drains {eop,sop,data} FIFO words into a framed valid/ready stream with IPG and
// packet/error counters. Optional destination filter (DROP state) under ETH_TX_DST_FILTER_EN.
module eth_tx_fsm #(
  parameter int unsigned IPG    = 2,
  parameter logic [31:0] A_ADDR = 32'habcd,
  parameter logic [31:0] B_ADDR = 32'hcdef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_empty,
  output logic        in_rd_en,
  input  logic [33:0] in_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRC  = 3'd1,
    S_DATA = 3'd2,
    S_GAP  = 3'd3
`ifdef ETH_TX_DST_FILTER_EN
    , S_DROP = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [33:0] hb0_q, hb0_d, hb1_q, hb1_d;
  logic [1:0]  hb_cnt_q, hb_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        head_vld, head_sop, head_eop;
  logic        xfer, slot_free, pop, load, ld_sop, ld_eop, idle_eval;
  logic [1:0]  err_inc;

  assign head_vld  = (hb_cnt_q != 2'd0);
  assign head_sop  = hb0_q[32];
  assign head_eop  = hb0_q[33];
  assign xfer      = out_valid_q && out_ready;
  assign slot_free = !out_valid_q || out_ready;

`ifdef ETH_TX_DST_FILTER_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        dst_ok;
  assign dst_ok   = (hb0_q[31:0] == A_ADDR) || (hb0_q[31:0] == B_ADDR);
  assign drop_cnt = drop_cnt_q;
`else
  logic unused_addr;
  assign unused_addr = ^{A_ADDR, B_ADDR};
  assign drop_cnt    = 16'd0;
`endif

  // Occupancy counts the word being consumed this cycle so the buffer sustains 1 word/cycle.
  assign in_rd_en  = rst && !in_empty &&
                     (({1'b0, hb_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop}) < 3'd2);
  assign rd_pend_d = in_rd_en;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pkt_cnt_d = pkt_cnt_q;
    pop       = 1'b0;
    load      = 1'b0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    err_inc   = 2'd0;
    idle_eval = 1'b0;
`ifdef ETH_TX_DST_FILTER_EN
    drop_cnt_d = drop_cnt_q;
`endif
    case (state_q)
      S_IDLE: idle_eval = head_vld;
      S_SRC, S_DATA: begin
        if (head_vld) begin
          if (head_sop && head_eop) begin
            pop     = 1'b1;
            err_inc = 2'd1;
            state_d = S_IDLE;
          end else if (slot_free) begin
            pop     = 1'b1;
            load    = 1'b1;
            ld_sop  = head_sop;
            ld_eop  = head_eop && !head_sop;
            err_inc = {1'b0, head_sop};
            if (head_sop)      state_d = S_SRC;
            else if (head_eop) state_d = S_GAP;
            else               state_d = S_DATA;
          end
        end
      end
      S_GAP: begin
        if (out_valid_q) begin
          // The eop word is still on the output; the gap starts once it transfers.
          if (out_ready) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (IPG == 0) state_d = S_IDLE;
            else          gap_d   = 4'(IPG - 1);
          end
        end else if (gap_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
`ifdef ETH_TX_DST_FILTER_EN
      S_DROP: begin
        if (head_vld) begin
          if (head_sop) begin
            if (slot_free) begin
              err_inc   = 2'd1;
              idle_eval = 1'b1;
            end
          end else begin
            pop = 1'b1;
            if (head_eop) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
              state_d    = S_IDLE;
            end
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (idle_eval) begin
      if (!head_sop || head_eop) begin
        pop     = 1'b1;
        err_inc = err_inc + 2'd1;
        state_d = S_IDLE;
      end
`ifdef ETH_TX_DST_FILTER_EN
      else if (!dst_ok) begin
        pop     = 1'b1;
        state_d = S_DROP;
      end
`endif
      else if (slot_free) begin
        pop     = 1'b1;
        load    = 1'b1;
        ld_sop  = 1'b1;
        state_d = S_SRC;
      end
    end

    err_cnt_d   = err_cnt_q + {14'd0, err_inc};
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = hb0_q[31:0];
      out_sop_d   = ld_sop;
      out_eop_d   = ld_eop;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    hb0_d    = hb0_q;
    hb1_d    = hb1_q;
    hb_cnt_d = hb_cnt_q;
    case ({pop, rd_pend_q})
      2'b10: begin
        hb0_d    = hb1_q;
        hb_cnt_d = hb_cnt_q - 2'd1;
      end
      2'b01: begin
        if (hb_cnt_q == 2'd0) hb0_d = in_rd_data;
        else                  hb1_d = in_rd_data;
        hb_cnt_d = hb_cnt_q + 2'd1;
      end
      2'b11: begin
        if (hb_cnt_q == 2'd1) begin
          hb0_d = in_rd_data;
        end else begin
          hb0_d = hb1_q;
          hb1_d = in_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gap_q       <= 4'd0;
      hb0_q       <= 34'd0;
      hb1_q       <= 34'd0;
      hb_cnt_q    <= 2'd0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
`ifdef ETH_TX_DST_FILTER_EN
      drop_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      hb0_q       <= hb0_d;
      hb1_q       <= hb1_d;
      hb_cnt_q    <= hb_cnt_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef ETH_TX_DST_FILTER_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_fsm.sv
`default_nettype none
// Scoreboard bench for eth_tx_fsm: directed packets queue expected words, a monitor compares transfers.
module tb_eth_tx_fsm;
  localparam int IPG = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [33:0] in_rd_data = 34'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_sop, out_eop;
  logic [15:0] pkt_cnt, err_cnt, drop_cnt;

  always #5 clk = ~clk;

  eth_tx_fsm #(.IPG(IPG), .A_ADDR(32'habcd), .B_ADDR(32'hcdef)) dut (
    .clk(clk), .rst(rst), .in_empty(in_empty), .in_rd_en(in_rd_en), .in_rd_data(in_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  logic [33:0] fifo_q[$];
  logic [33:0] exp_q[$];
  int          xfer_log[$];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, rd_count = 0, n_xfer = 0, last_eop_cyc = -1;
  int          exp_pkt = 0, exp_err = 0, rd_base = 0, n0 = 0;
  logic        stall_chk = 1'b0;
  logic [33:0] held = 34'd0;
  logic [3:0]  pat = 4'b1001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word queued in the FIFO and expected unchanged on the output.
  task automatic fwd(input logic eop, input logic sop, input logic [31:0] d);
    fifo_q.push_back({eop, sop, d});
    exp_q.push_back({eop, sop, d});
  endtask

  // Word queued in the FIFO that must never reach the output.
  task automatic dropw(input logic eop, input logic sop, input logic [31:0] d);
    fifo_q.push_back({eop, sop, d});
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #2;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_counters(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  // FIFO model: pop on in_rd_en, data valid the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_rd_en && fifo_q.size() > 0) begin
      in_rd_data <= fifo_q.pop_front();
      rd_count   <= rd_count + 1;
    end
    in_empty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      stall_chk    = 1'b0;
      last_eop_cyc = -1;
    end else begin
      if (stall_chk)
        check("stall_hold", {out_valid, out_eop, out_sop, out_data}, {1'b1, held});
      stall_chk = 1'b0;
      if (out_valid && out_ready) begin
        xfer_log.push_back(cyc + 1);
        n_xfer++;
        if (out_sop && last_eop_cyc >= 0)
          check("ipg_gap", 64'((cyc + 1 - last_eop_cyc) >= IPG + 1), 64'd1);
        if (out_eop) last_eop_cyc = cyc + 1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_word: got %h, expected no transfer", {out_eop, out_sop, out_data});
        end else begin
          check("word", {out_eop, out_sop, out_data}, exp_q.pop_front());
        end
      end else if (out_valid) begin
        stall_chk = 1'b1;
        held      = {out_eop, out_sop, out_data};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a packet already waiting in the FIFO.
    repeat (2) @(posedge clk);
    #1;
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef);
    fwd(1'b0, 1'b0, 32'h1111); fwd(1'b1, 1'b0, 32'h2222);
    @(posedge clk); #1;
    check("rst_in_rd_en", in_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", {out_eop, out_sop, out_data}, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    xfer_log.delete();
    rst = 1'b1;

    // Basic 4-word packet at full rate.
    wait_drain(50);
    exp_pkt = 1;
    check("t1_xfers", xfer_log.size(), 4);
    if (xfer_log.size() == 4) check("t1_consecutive", xfer_log[3] - xfer_log[0], 3);
    check("t1_pkt_cnt", pkt_cnt, exp_pkt);
    @(negedge clk); check("t1_gap1_valid", out_valid, 0);
    @(negedge clk); check("t1_gap2_valid", out_valid, 0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: full stall fills the holding buffer, then a 1,0,0,1 ready pattern.
    out_ready = 1'b0;
    rd_base   = rd_count;
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef); fwd(1'b0, 1'b0, 32'h1);
    fwd(1'b0, 1'b0, 32'h2);    fwd(1'b0, 1'b0, 32'h3);    fwd(1'b1, 1'b0, 32'h4);
    repeat (12) @(posedge clk);
    #1;
    check("t2_stall_reads", rd_count - rd_base, 3);
    check("t2_stall_rd_en", in_rd_en, 0);
    check("t2_stall_word", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 32'habcd});
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) begin
      out_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain(20);
    exp_pkt++;
    check_counters("t2");

    // Orphan payload word and a runt, then a legal 2-word packet.
    dropw(1'b0, 1'b0, 32'h5555); dropw(1'b1, 1'b1, 32'h6666);
    fwd(1'b0, 1'b1, 32'habcd);   fwd(1'b1, 1'b0, 32'h1);
    exp_err += 2; exp_pkt++;
    wait_drain(50);
    check_counters("t3");

    // Mid-packet sop: truncated packet, restart framed from the second sop.
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef);
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef); fwd(1'b1, 1'b0, 32'h9);
    exp_err += 1; exp_pkt++;
    wait_drain(50);
    check_counters("t4");

    // Reset mid-payload.
    n0 = n_xfer;
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef); fwd(1'b0, 1'b0, 32'h10);
    fwd(1'b0, 1'b0, 32'h11);   fwd(1'b0, 1'b0, 32'h12);   fwd(1'b1, 1'b0, 32'h13);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (n_xfer - n0 >= 2) break;
    end
    check("t5_started", 64'(n_xfer - n0 >= 2), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_rd_en", in_rd_en, 0);
    check("t5_rst_out_word", {out_eop, out_sop, out_data}, 0);
    check("t5_rst_pkt_cnt", pkt_cnt, 0);
    check("t5_rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    fifo_q.delete();
    exp_pkt = 0; exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    fwd(1'b0, 1'b1, 32'habcd); fwd(1'b0, 1'b0, 32'hcdef); fwd(1'b1, 1'b0, 32'h7777);
    exp_pkt = 1;
    wait_drain(50);
    check_counters("t5");

`ifdef ETH_TX_DST_FILTER_EN
    // Unknown destination is dropped silently; known destination forwarded.
    dropw(1'b0, 1'b1, 32'h1234); dropw(1'b0, 1'b0, 32'h1);
    dropw(1'b0, 1'b0, 32'h2);    dropw(1'b1, 1'b0, 32'h3);
    fwd(1'b0, 1'b1, 32'habcd);   fwd(1'b0, 1'b0, 32'hcdef); fwd(1'b1, 1'b0, 32'h8);
    exp_pkt++;
    wait_drain(60);
    check_counters("t6");
    check("t6_drop_cnt", drop_cnt, 1);
`else
    check("drop_cnt_zero", drop_cnt, 0);
`endif

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
